// File: rtl/mux4_rr_sched_if.sv
// Bundle of requester, grant and data-path signals between the round-robin
// scheduler and the agents that request the shared 4:1 mux.
interface mux4_rr_sched_if;
  logic [3:0] req;
  logic       p;
  logic       q;
  logic       r;
  logic       s;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out;
  logic       valid;
  logic       dbg_state;  // 0 = IDLE, 1 = GRANT
  logic [1:0] dbg_ptr;

  modport master (
    output req, p, q, r, s,
    input  gnt, sel, out, valid, dbg_state, dbg_ptr
  );

  modport slave (
    input  req, p, q, r, s,
    output gnt, sel, out, valid, dbg_state, dbg_ptr
  );
endinterface

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler for one shared 4:1 single-bit mux. Each grant lasts at
// most HOLD cycles and is followed by one IDLE cycle; the selected bit is registered.
module mux4_rr_sched #(
  parameter int unsigned HOLD = 4
) (
  input  logic            clk,
  input  logic            rst,
  mux4_rr_sched_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [3:0] HOLD_C = 4'(HOLD);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       out_q;
  logic       valid_q;

  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic [3:0] data_vec;
  logic       req_sel;
  logic       beat;

  assign data_vec = {bus.s, bus.r, bus.q, bus.p};
  assign req_sel  = bus.req[sel_q];
  assign beat     = (state_q == GRANT) && req_sel;

  // First set request bit scanning upward from ptr, wrapping mod 4.
  always_comb begin
    win   = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          cnt_d   = 4'd1;
        end
      end
      GRANT: begin
        // sel is left alone on release so the mux input stays stable.
        if (!req_sel || (cnt_q == HOLD_C)) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = sel_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= beat;
      if (beat) begin
        out_q <= data_vec[sel_q];
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out       = out_q;
  assign bus.valid     = valid_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_ptr   = ptr_q;

endmodule

// File: doc/mux4_rr_sched.md
# mux4_rr_sched

Round-robin scheduler that shares one 4:1 single-bit mux (`mux4x1`) among four requesters. It arbitrates the request lines, drives the mux select, and caps each grant at `HOLD` cycles. It also registers the selected data bit with a valid strobe for the downstream consumer. The block sits directly in front of the `mux4x1` instance, and its `sel` output drives that mux's `sel` input.

## Interface
- `HOLD`, default 4: maximum grant length in cycles; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  4  request lines; bit i belongs to requester i (0=p, 1=q, 2=r, 3=s).
- `p`, `q`, `r`, `s`  in  1 each  requester data bits; these also feed the mux data inputs.
- `gnt`  out  4  one-hot grant; all zero when no grant is active.
- `sel`  out  2  mux select; index of the current or most recent grantee.
- `out`  out  1  registered copy of the selected data bit.
- `valid`  out  1  `out` carries a valid beat.

## Operation
- Reset values: state IDLE, `gnt`=0000, `sel`=00, round-robin pointer `ptr`=0, `cnt`=0, `out`=0, `valid`=0.
- The FSM has two states, IDLE and GRANT.
- **IDLE:**
  - If `req`≠0, choose the first set bit scanning `ptr`, `ptr`+1, … mod 4.
  - At the next edge: state←GRANT, `gnt`←onehot(winner), `sel`←winner, `cnt`←1.
  - If `req`=0, remain in IDLE; `sel` holds its last value so the mux stays stable.
- **GRANT:**
  - At each edge, if `req[sel]`=0 or `cnt`=`HOLD`: release. That is, state←IDLE, `gnt`←0, `ptr`←(`sel`+1) mod 4, `sel` unchanged.
  - Otherwise `cnt`←`cnt`+1.
- Arbitration happens only in IDLE. Request changes during GRANT never preempt the current grant.
- **Data path:**
  - Every edge: `valid`←(state=GRANT && `req[sel]`).
  - When that condition is true, `out`←{s,r,q,p}[`sel`]; otherwise `out` holds.
- `cnt` is 4 bits and never exceeds `HOLD`.
- `gnt` is always one-hot or zero, and `gnt`≠0 exactly when the state is GRANT.

## Timing
- Request to grant is 1 cycle: `req` sampled high in IDLE at edge E gives `gnt`/`sel` valid after E.
- Grant to first `valid`: 1 cycle (`out` is registered).
- A grant whose request stays high lasts exactly `HOLD` cycles and yields exactly `HOLD` valid beats.
- If the request drops in grant cycle k (sampled low at the edge), the release happens at that edge. The grant yields k−1 valid beats, and `valid` is 0 in the cycle after the drop.
- After every release there is one mandatory IDLE cycle, so back-to-back grants are `HOLD`+1 cycles apart.
- With all four requests held high, service order is 0,1,2,3,0,… and each requester gets `HOLD` beats per `4*(HOLD+1)` cycles.
- `HOLD`=1 gives one beat per grant, alternating GRANT and IDLE.
- A request that rises in the same cycle as a release is evaluated in the following IDLE cycle against the updated `ptr`.
- Reset asserted mid-grant clears all state and outputs immediately, without waiting for a clock edge. The first arbitration after reset uses `ptr`=0.

## Test plan
- **Reset:** assert `rst` during an active grant with `sel`=2.
  - Immediately: `gnt`=0000, `valid`=0, `out`=0, `sel`=00.
  - After release, with `req`=1111: first grant goes to 0.
- **Single requester:** `HOLD`=4, `req`=0010 held, q=1.
  - `gnt`=0010 and `sel`=01 one cycle after `req` rises.
  - `valid`=1 for 4 cycles with `out`=1.
  - Then 1 IDLE cycle, then requester 1 is re-granted.
- **Round-robin fairness:** `req`=1111, `HOLD`=2, p=0,q=1,r=0,s=1.
  - Grant sequence `sel`=0,1,2,3,0, each lasting 2 cycles separated by 1 IDLE cycle.
  - `out` beats: 0,0,1,1,0,0,1,1.
- **Early drop:** `req`=0100 granted, `HOLD`=4; drop `req[2]` during the second grant cycle.
  - Exactly 1 valid beat.
  - `gnt`=0000 at the edge where the drop is sampled.
  - `ptr`=3, so with a later `req`=1001 requester 3 wins.
- **No preemption:** requester 3 is granted; raise `req[0]` mid-grant.
  - `gnt` stays 1000 until `HOLD` expires.
  - Next grant goes to 0 (`ptr` wrapped from 3 to 0).
- **Data tracking:** `sel`=1 granted, toggle q every cycle.
  - `out` follows q delayed by one cycle while `valid`=1.
  - `out` holds its last value once `valid`=0.
